// File: rtl/encoder_slave_emu_if.sv
// Serial link, snapshot inputs and status outputs of the encoder slave emulator.
// ENC_SLAVE_CRC_INJ_EN adds the iCrcInj CRC-inversion request.
interface encoder_slave_emu_if;
  logic        iRx;
  logic        oTx;
  logic        oDir;
  logic [23:0] iAbs;
  logic [23:0] iAbm;
  logic [7:0]  iSf;
  logic [7:0]  iAlmc;
  logic        oBusy;
  logic        oReqErr;
`ifdef ENC_SLAVE_CRC_INJ_EN
  logic        iCrcInj;

  modport slave  (input iRx, iAbs, iAbm, iSf, iAlmc, iCrcInj, output oTx, oDir, oBusy, oReqErr);
  modport master (output iRx, iAbs, iAbm, iSf, iAlmc, iCrcInj, input oTx, oDir, oBusy, oReqErr);
`else
  modport slave  (input iRx, iAbs, iAbm, iSf, iAlmc, output oTx, oDir, oBusy, oReqErr);
  modport master (output iRx, iAbs, iAbm, iSf, iAlmc, input oTx, oDir, oBusy, oReqErr);
`endif
endinterface

// File: rtl/encoder_slave_emu.sv
// Absolute-encoder slave emulator: decodes a CF request byte and answers with the data frame.
// ENC_SLAVE_CRC_INJ_EN enables optional CRC-byte inversion for master error-path testing.
module encoder_slave_emu #(
  parameter int unsigned CLKS_PER_BIT    = 40,
  parameter int unsigned TURNAROUND_CLKS = 300,
  parameter logic [7:0]  ENID            = 8'h17
) (
  input  logic               nclk_100m,
  input  logic               iRst_n,
  encoder_slave_emu_if.slave bus
);
  localparam int unsigned MAX_CLKS = (CLKS_PER_BIT > TURNAROUND_CLKS) ? CLKS_PER_BIT : TURNAROUND_CLKS;
  localparam int unsigned CNT_W    = $clog2(MAX_CLKS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RX     = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_TURN   = 3'd3;
  localparam logic [2:0] S_LEAD   = 3'd4;
  localparam logic [2:0] S_TX     = 3'd5;
  localparam logic [2:0] S_TAIL   = 3'd6;

  localparam logic [7:0] CF_ID0 = 8'h02;
  localparam logic [7:0] CF_ID1 = 8'h8A;
  localparam logic [7:0] CF_ID3 = 8'h1A;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [3:0]       byte_q, byte_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       cf_q, cf_d;
  logic [7:0]       sf_q, sf_d;
  logic [7:0]       almc_q, almc_d;
  logic [23:0]      abs_q, abs_d;
  logic [23:0]      abm_q, abm_d;
  logic             tx_q, tx_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
`ifdef ENC_SLAVE_CRC_INJ_EN
  logic             crcinj_q, crcinj_d;
`endif

  logic [7:0]  abs_x_c, abm_x_c, crc_c, byte_c;
  logic [23:0] word_c;
  logic [3:0]  last_c, nbit_c;
  logic [9:0]  frame_c;

  // Two-flop synchronizer plus previous value for falling-edge detection
  always_ff @(posedge nclk_100m or negedge iRst_n) begin
    if (!iRst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.iRx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign abs_x_c = abs_q[7:0] ^ abs_q[15:8] ^ abs_q[23:16];
  assign abm_x_c = abm_q[7:0] ^ abm_q[15:8] ^ abm_q[23:16];
  assign nbit_c  = bit_q + 4'd1;
  assign frame_c = {1'b1, byte_c, 1'b0};

  // Reply byte selection and CRC, all from the latched snapshot
  always_comb begin
    word_c = (cf_q == CF_ID1) ? abm_q : abs_q;
    last_c = 4'd5;
    crc_c  = cf_q ^ sf_q ^ ((cf_q == CF_ID1) ? abm_x_c : abs_x_c);
    if (cf_q == CF_ID3) begin
      last_c = 4'd10;
      crc_c  = cf_q ^ sf_q ^ abs_x_c ^ ENID ^ abm_x_c ^ almc_q;
    end
`ifdef ENC_SLAVE_CRC_INJ_EN
    crc_c = crc_c ^ {8{crcinj_q}};
`endif
    byte_c = crc_c;
    if (cf_q == CF_ID3) begin
      case (byte_q)
        4'd0:    byte_c = cf_q;
        4'd1:    byte_c = sf_q;
        4'd2:    byte_c = abs_q[7:0];
        4'd3:    byte_c = abs_q[15:8];
        4'd4:    byte_c = abs_q[23:16];
        4'd5:    byte_c = ENID;
        4'd6:    byte_c = abm_q[7:0];
        4'd7:    byte_c = abm_q[15:8];
        4'd8:    byte_c = abm_q[23:16];
        4'd9:    byte_c = almc_q;
        default: byte_c = crc_c;
      endcase
    end else begin
      case (byte_q)
        4'd0:    byte_c = cf_q;
        4'd1:    byte_c = sf_q;
        4'd2:    byte_c = word_c[7:0];
        4'd3:    byte_c = word_c[15:8];
        4'd4:    byte_c = word_c[23:16];
        default: byte_c = crc_c;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    cf_d    = cf_q;
    sf_d    = sf_q;
    almc_d  = almc_q;
    abs_d   = abs_q;
    abm_d   = abm_q;
    tx_d    = tx_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
`ifdef ENC_SLAVE_CRC_INJ_EN
    crcinj_d = crcinj_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        dir_d  = 1'b0;
        busy_d = 1'b0;
        if (rx_prev_q && !rx_sync_q) begin
          state_d = S_RX;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      // Start bit sampled at half a bit, data and stop bits one bit apart after that
      S_RX: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (( (bit_q == 4'd0) && (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1))) ||
            ( (bit_q != 4'd0) && (cnt_q == CNT_W'(CLKS_PER_BIT - 1)))) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd0) begin
            if (rx_sync_q) state_d = S_IDLE;
          end else if (bit_q == 4'd9) begin
            if (!rx_sync_q) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_DECODE;
              busy_d  = 1'b1;
              cf_d    = sh_q;
              sf_d    = bus.iSf;
              almc_d  = bus.iAlmc;
              abs_d   = bus.iAbs;
              abm_d   = bus.iAbm;
`ifdef ENC_SLAVE_CRC_INJ_EN
              crcinj_d = bus.iCrcInj;
`endif
            end
          end else begin
            sh_d = {rx_sync_q, sh_q[7:1]};
          end
        end
      end
      S_DECODE: begin
        cnt_d  = cnt_q + CNT_W'(1);
        bit_d  = '0;
        byte_d = '0;
        if ((cf_q == CF_ID0) || (cf_q == CF_ID1) || (cf_q == CF_ID3)) begin
          state_d = S_TURN;
        end else begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      // Counter keeps running from the stop-bit sample through decode
      S_TURN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(TURNAROUND_CLKS - 2)) begin
          cnt_d   = '0;
          dir_d   = 1'b1;
          state_d = S_LEAD;
        end
      end
      S_LEAD: begin
        cnt_d = cnt_q + CNT_W'(1);
        tx_d  = 1'b1;
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          tx_d    = 1'b0;
          state_d = S_TX;
        end
      end
      S_TX: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (bit_q == 4'd9) begin
            if (byte_q == last_c) begin
              tx_d    = 1'b1;
              state_d = S_TAIL;
            end else begin
              byte_d = byte_q + 4'd1;
              bit_d  = '0;
              tx_d   = 1'b0;
            end
          end else begin
            bit_d = nbit_c;
            tx_d  = frame_c[nbit_c];
          end
        end
      end
      S_TAIL: begin
        cnt_d = cnt_q + CNT_W'(1);
        tx_d  = 1'b1;
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          dir_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        dir_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge nclk_100m or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      cf_q    <= '0;
      sf_q    <= '0;
      almc_q  <= '0;
      abs_q   <= '0;
      abm_q   <= '0;
      tx_q    <= 1'b1;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef ENC_SLAVE_CRC_INJ_EN
      crcinj_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      cf_q    <= cf_d;
      sf_q    <= sf_d;
      almc_q  <= almc_d;
      abs_q   <= abs_d;
      abm_q   <= abm_d;
      tx_q    <= tx_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef ENC_SLAVE_CRC_INJ_EN
      crcinj_q <= crcinj_d;
`endif
    end
  end

  assign bus.oTx     = tx_q;
  assign bus.oDir    = dir_q;
  assign bus.oBusy   = busy_q;
  assign bus.oReqErr = err_q;

endmodule

// File: tb/tb_encoder_slave_emu.sv
// Bench for encoder_slave_emu: directed and random requests, reply frames checked against a byte-list model.
module tb_encoder_slave_emu;
  localparam int CPB = 40;
  localparam int TA  = 300;
  localparam logic [7:0] ENID = 8'h17;

  logic nclk_100m = 1'b0;
  logic iRst_n    = 1'b0;

  encoder_slave_emu_if bus ();

  encoder_slave_emu #(
    .CLKS_PER_BIT   (CPB),
    .TURNAROUND_CLKS(TA),
    .ENID           (ENID)
  ) dut (
    .nclk_100m(nclk_100m),
    .iRst_n   (iRst_n),
    .bus      (bus)
  );

  always #5 nclk_100m = ~nclk_100m;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0, err_hi = 0, dir_hi = 0, txlo_idle = 0;

  // Free-running observers of output activity
  always @(negedge nclk_100m) begin
    cyc <= cyc + 1;
    if (bus.oReqErr) err_hi <= err_hi + 1;
    if (bus.oDir) dir_hi <= dir_hi + 1;
    if (!bus.oDir && !bus.oTx) txlo_idle <= txlo_idle + 1;
  end

  logic [7:0] exp_q[$];
  logic [7:0] got[$];
  int         dir_cyc, t_first;
  bit         tmo;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: header, payload by request type, then XOR of everything before it
  task automatic build_exp(input logic [7:0] cf, input logic [23:0] abs, input logic [23:0] abm,
                           input logic [7:0] sf, input logic [7:0] almc, input bit inj);
    logic [7:0] crc;
    exp_q.delete();
    exp_q.push_back(cf);
    exp_q.push_back(sf);
    if (cf == 8'h8A) begin
      for (int i = 0; i < 3; i++) exp_q.push_back(abm[8*i +: 8]);
    end else begin
      for (int i = 0; i < 3; i++) exp_q.push_back(abs[8*i +: 8]);
    end
    if (cf == 8'h1A) begin
      exp_q.push_back(ENID);
      for (int i = 0; i < 3; i++) exp_q.push_back(abm[8*i +: 8]);
      exp_q.push_back(almc);
    end
    crc = 8'h00;
    foreach (exp_q[i]) crc = crc ^ exp_q[i];
    if (inj) crc = ~crc;
    exp_q.push_back(crc);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, output int t_stop);
    logic [9:0] w;
    w = {stop, b, 1'b0};
    t_stop = cyc;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) t_stop = cyc;
      bus.iRx = w[i];
      repeat (CPB) @(negedge nclk_100m);
    end
    bus.iRx = 1'b1;
  endtask

  task automatic get_reply();
    int e, k;
    bit active;
    logic [7:0] sh;
    got.delete();
    dir_cyc = 0; tmo = 1'b0; t_first = -1; active = 1'b0; e = 0; sh = 8'h00;
    for (int i = 0; i < 2000 && !bus.oDir; i++) @(negedge nclk_100m);
    if (!bus.oDir) begin
      tmo = 1'b1;
      return;
    end
    while (bus.oDir && dir_cyc < 20000) begin
      dir_cyc++;
      if (!active) begin
        if (!bus.oTx) begin
          active = 1'b1;
          e = 0;
          if (t_first < 0) t_first = cyc;
        end
      end else begin
        e++;
        if (e % CPB == CPB / 2) begin
          k = e / CPB;
          if (k >= 1 && k <= 8) sh[k-1] = bus.oTx;
          else if (k == 9) begin
            check("stop_bit", 32'(bus.oTx), 32'd1);
            got.push_back(sh);
            active = 1'b0;
          end
        end
      end
      @(negedge nclk_100m);
    end
  endtask

  task automatic verify_reply(input string tag, input int ts);
    int lat;
    check({tag, "_tmo"}, 32'(tmo), 32'd0);
    check({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    check({tag, "_dir"}, 32'(dir_cyc), 32'((exp_q.size() * 10 + 2) * CPB));
    lat = t_first - ts;
    check({tag, "_lat"}, 32'((lat >= CPB / 2 + TA + CPB - 2) && (lat <= CPB / 2 + TA + CPB + 6)), 32'd1);
    check({tag, "_busy"}, 32'(bus.oBusy), 32'd0);
    repeat (20) @(negedge nclk_100m);
  endtask

  task automatic run_txn(input string tag, input logic [7:0] cf);
    int ts;
    send_byte(cf, 1'b1, ts);
    get_reply();
    verify_reply(tag, ts);
  endtask

  task automatic run_bad(input string tag, input logic [7:0] cf, input logic stop);
    int ts, e0, d0;
    e0 = err_hi; d0 = dir_hi;
    send_byte(cf, stop, ts);
    repeat (500) @(negedge nclk_100m);
    check({tag, "_err"}, 32'(err_hi - e0), 32'd1);
    check({tag, "_dir"}, 32'(dir_hi - d0), 32'd0);
    check({tag, "_tx"}, 32'(txlo_idle), 32'd0);
  endtask

  initial begin
    int ts, e0;
    logic [7:0] cf;
    logic [7:0] cfs[3];
    bit inj;
    cfs[0] = 8'h02; cfs[1] = 8'h8A; cfs[2] = 8'h1A;
    inj = 1'b0;
    bus.iRx = 1'b1; bus.iAbs = 24'h0; bus.iAbm = 24'h0; bus.iSf = 8'h0; bus.iAlmc = 8'h0;
`ifdef ENC_SLAVE_CRC_INJ_EN
    bus.iCrcInj = 1'b0;
`endif
    repeat (5) @(negedge nclk_100m);
    check("rst_tx", 32'(bus.oTx), 32'd1);
    check("rst_dir", 32'(bus.oDir), 32'd0);
    check("rst_busy", 32'(bus.oBusy), 32'd0);
    check("rst_err", 32'(bus.oReqErr), 32'd0);
    iRst_n = 1'b1;
    repeat (10) @(negedge nclk_100m);

    bus.iAbs = 24'h012345; bus.iAbm = 24'h000007; bus.iSf = 8'h00; bus.iAlmc = 8'h00;
    build_exp(8'h02, bus.iAbs, bus.iAbm, bus.iSf, bus.iAlmc, 1'b0);
    check("id0_model_crc", 32'(exp_q[5]), 32'h65);
    run_txn("id0", 8'h02);
    build_exp(8'h8A, bus.iAbs, bus.iAbm, bus.iSf, bus.iAlmc, 1'b0);
    run_txn("id1", 8'h8A);
    build_exp(8'h1A, bus.iAbs, bus.iAbm, bus.iSf, bus.iAlmc, 1'b0);
    run_txn("id3", 8'h1A);

    run_bad("badcf", 8'h55, 1'b1);
    run_bad("frame", 8'h02, 1'b0);

    // Inputs change and iRx pulses low mid-reply; frame must follow the snapshot
    build_exp(8'h02, bus.iAbs, bus.iAbm, bus.iSf, bus.iAlmc, 1'b0);
    e0 = err_hi;
    send_byte(8'h02, 1'b1, ts);
    fork
      get_reply();
      begin
        repeat (1200) @(negedge nclk_100m);
        bus.iAbs = 24'hFFFFFF;
        bus.iRx  = 1'b0;
        repeat (450) @(negedge nclk_100m);
        bus.iRx  = 1'b1;
      end
    join
    verify_reply("snap", ts);
    repeat (500) @(negedge nclk_100m);
    check("snap_noerr", 32'(err_hi - e0), 32'd0);
    check("snap_idle_dir", 32'(bus.oDir), 32'd0);
    bus.iAbs = 24'h012345;

    // Reset in the middle of the third reply byte
    send_byte(8'h02, 1'b1, ts);
    for (int i = 0; i < 2000 && !bus.oDir; i++) @(negedge nclk_100m);
    repeat (CPB + 2 * 10 * CPB + 5 * CPB) @(negedge nclk_100m);
    check("pre_rst_dir", 32'(bus.oDir), 32'd1);
    iRst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(bus.oTx), 32'd1);
    check("mid_rst_dir", 32'(bus.oDir), 32'd0);
    check("mid_rst_busy", 32'(bus.oBusy), 32'd0);
    @(negedge nclk_100m);
    repeat (3) @(negedge nclk_100m);
    iRst_n = 1'b1;
    repeat (10) @(negedge nclk_100m);
    build_exp(8'h02, bus.iAbs, bus.iAbm, bus.iSf, bus.iAlmc, 1'b0);
    run_txn("post_rst", 8'h02);

`ifdef ENC_SLAVE_CRC_INJ_EN
    bus.iCrcInj = 1'b1;
    build_exp(8'h02, bus.iAbs, bus.iAbm, bus.iSf, bus.iAlmc, 1'b1);
    check("inj_model_crc", 32'(exp_q[5]), 32'h9A);
    run_txn("inj", 8'h02);
    bus.iCrcInj = 1'b0;
`endif

    for (int t = 0; t < 5; t++) begin
      cf = cfs[$urandom_range(0, 2)];
      bus.iAbs  = 24'($urandom);
      bus.iAbm  = 24'($urandom);
      bus.iSf   = 8'($urandom);
      bus.iAlmc = 8'($urandom);
`ifdef ENC_SLAVE_CRC_INJ_EN
      inj = 1'($urandom_range(0, 1));
      bus.iCrcInj = inj;
`endif
      build_exp(cf, bus.iAbs, bus.iAbm, bus.iSf, bus.iAlmc, inj);
      run_txn($sformatf("rnd%0d", t), cf);
    end

    cf = 8'($urandom);
    while (cf == 8'h02 || cf == 8'h8A || cf == 8'h1A) cf = 8'($urandom);
    run_bad("rnd_badcf", cf, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/encoder_slave_emu.md
Name: encoder_slave_emu

Overview:
Responder side of the absolute-encoder serial link. It receives a control-field (CF) request byte on the half-duplex RS-485 line and returns the matching data frame built from position, multiturn and alarm inputs. It plugs in where the physical encoder normally sits, so the encoder data-treatment path and the current loop can run hardware-in-loop and in simulation without a motor.

Parameters:
CLKS_PER_BIT, 40, clocks per UART bit (100 MHz / 2.5 Mbps)
TURNAROUND_CLKS, 300, clocks from the request stop-bit mid-sample to oDir rise
ENID, 8'h17, fixed encoder-ID byte returned in the DATA ID3 frame

Ports:
nclk_100m  input  1  system clock, 100 MHz
iRst_n  input  1  asynchronous active-low reset
iRx  input  1  serial request from master (master oTx), idle high
oTx  output  1  serial reply to master (master iRx), idle high
oDir  output  1  RS-485 driver enable, 1 = slave drives the line
iAbs  input  24  single-turn position, sent as ABS0..ABS2, LSB byte first
iAbm  input  24  multiturn count, sent as ABM0..ABM2, LSB byte first
iSf  input  8  status field byte
iAlmc  input  8  alarm code byte
oBusy  output  1  high from request decode until oDir falls
oReqErr  output  1  one-cycle pulse on an unsupported CF or a framing error

Behaviour:
- Reset: clock nclk_100m; reset iRst_n, asynchronous, active-low. On reset oTx=1, oDir=0, oBusy=0, oReqErr=0, FSM=IDLE, all counters cleared. Reset asserted mid-reply drops oTx/oDir to idle immediately.
- Serial format: UART 8N1, LSB first. iRx passes through a 2-flop synchronizer before use.
- RX: a falling edge on synced iRx in IDLE starts reception. Start bit is sampled at CLKS_PER_BIT/2 and must read 0, otherwise the edge is a glitch: return to IDLE with no error. Data bits are sampled every CLKS_PER_BIT after that, then the stop bit. A stop bit of 0 is a framing error: oReqErr pulses, return to IDLE.
- iRx is ignored while oBusy=1, so the slave does not echo its own reply.
- Decode:
  - CF=8'h02 (ID0) reply: CF, SF, ABS0, ABS1, ABS2, CRC. 6 bytes.
  - CF=8'h8A (ID1) reply: CF, SF, ABM0, ABM1, ABM2, CRC. 6 bytes.
  - CF=8'h1A (ID3) reply: CF, SF, ABS0-2, ENID, ABM0-2, ALMC, CRC. 11 bytes.
  - Any other CF: oReqErr pulse, no reply, return to IDLE.
- Snapshot: iAbs, iAbm, iSf and iAlmc are latched in the cycle the stop bit validates. Input changes during the reply do not affect the frame.
- CRC: XOR of all preceding bytes of the frame, CF included.
- FSM: IDLE -> RX -> DECODE -> TURN -> LEAD -> TX -> TAIL -> IDLE.
  - TURN waits TURNAROUND_CLKS counted from the stop-bit mid-sample, then raises oDir.
  - LEAD holds oTx=1 for CLKS_PER_BIT.
  - TX sends the bytes back-to-back, 10 bits each, with no inter-byte gap.
  - TAIL holds oDir=1 for CLKS_PER_BIT after the last stop bit ends, then clears oDir and oBusy.
- Timing: oBusy rises 1 cycle after the stop-bit sample. First reply start bit edge = stop sample + TURNAROUND_CLKS + CLKS_PER_BIT (±1 cycle).
- Counters: the bit-timing counter is sized $clog2(max(CLKS_PER_BIT, TURNAROUND_CLKS)+1). The byte index wraps only via return to IDLE.
- oTx is registered and glitch-free. oTx=1 whenever oDir=0.

Optional Feature:
ENC_SLAVE_CRC_INJ_EN:
- When defined: adds input iCrcInj (1 bit), sampled with the snapshot. If iCrcInj=1, the transmitted CRC byte is bitwise inverted so the master's CRC-check path can be exercised.
- When undefined: the port and its logic are absent, and the CRC is always correct.

Test Plan:
- iAbs=24'h012345, iSf=8'h00, send CF 8'h02 -> reply bytes 02 00 45 23 01 65; oDir high for (6*10+2)*40 clocks; oBusy low afterwards.
- iAbm=24'h000007, send CF 8'h8A -> reply bytes 8A 00 07 00 00 8D.
- iAbs=24'h012345, iAbm=24'h000007, iAlmc=8'h00, send CF 8'h1A -> reply bytes 1A 00 45 23 01 17 07 00 00 00 6D (11 bytes).
- Send CF 8'h55 -> oReqErr pulses exactly 1 cycle; oDir stays 0; oTx stays 1. Send CF 8'h02 with stop bit forced 0 -> oReqErr pulse, no reply.
- Change iAbs to 24'hFFFFFF during the ID0 reply -> transmitted ABS bytes still 45 23 01. Pulse iRx low during the reply -> no effect.
- Assert iRst_n=0 during the 3rd reply byte -> oTx=1, oDir=0, oBusy=0 within the same cycle. After release, CF 8'h02 gets a normal full reply. With ENC_SLAVE_CRC_INJ_EN defined and iCrcInj=1, the ID0 CRC byte is 9A.
